data_mem_arbiter: RTL and testbench

- Two-requester controller in front of the data memory: port 0 is the CPU load/store unit, port 1 is the test/debug loader.
- Arbitrates between the ports round-robin and checks each request (alignment, range).
- Sequences one doubleword access at a time onto the memory's single registered port.
- Returns the read data, or a write acknowledge, with a valid/ready handshake.

---
 rtl/data_mem_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 53 +++++
 rtl/data_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg
// Shared definitions for the data memory arbiter: transaction FSM states,
// requester port indices, the default memory size and the request error check.
// No ports (package).
package data_mem_ctrl_pkg;

    // One transaction walks IDLE -> CMD -> CAPT -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int MEM_SIZE_DEFAULT = 1024;

    // A request is rejected when it is not doubleword aligned (if alignment
    // checking is enabled) or when the doubleword would run past the end of
    // memory.
    function automatic logic req_error(input logic [63:0] addr,
                                       input int          mem_size,
                                       input bit          check_align);
        logic misaligned;
        logic out_of_range;
        misaligned   = check_align && (addr[2:0] != 3'b000);
        out_of_range = addr > (64'(mem_size) - 64'd8);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. Holds the index of the last granted port and
// gives a tie to the other port.
// Ports:
//   Clock   in   clock
//   ResetL  in   synchronous active-low reset (last grant returns to 1)
//   req     in   [1:0] request vector
//   update  in   a grant was accepted this cycle; record it
//   last    in   index of the port accepted this cycle
//   grant   out  [1:0] one-hot grant (combinational)
module rr_arbiter2
    import data_mem_ctrl_pkg::*;
(
    input  logic       Clock,
    input  logic       ResetL,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // Remember who won on every accept so the next tie goes the other way.
    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = last;
        end
    end

    // Reset to the debug port so the CPU port wins the first tie.
    always_ff @(posedge Clock) begin
        if (!ResetL) begin
            last_grant_q <= PORT_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // A lone requester always wins; on a tie the port that did not win last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == PORT_DBG) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Two-requester front end for the data memory (port 0 = CPU load/store unit,
// port 1 = test/debug loader). Arbitrates round-robin, checks each request
// for alignment and range, runs one doubleword access at a time on the
// memory's registered port and returns read data or a write acknowledge.
// Ports:
//   Clock, ResetL                 clock, synchronous active-low reset
//   ReqValid/Ready/Write/Addr/WData 0,1   request handshake per port
//   RspValid0/1, RspReady0/1      response handshake per port
//   RspRData, RspErr              shared response data and error flag
//   MemAddress, MemWriteData      memory address / store data
//   MemRead, MemWrite             one-cycle memory strobes
//   MemReadData                   memory output, valid the cycle after MemRead
module data_mem_arbiter
    import data_mem_ctrl_pkg::*;
#(
    parameter int MEM_SIZE    = MEM_SIZE_DEFAULT,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        Clock,
    input  logic        ResetL,
    input  logic        ReqValid0,
    input  logic        ReqValid1,
    output logic        ReqReady0,
    output logic        ReqReady1,
    input  logic        ReqWrite0,
    input  logic        ReqWrite1,
    input  logic [63:0] ReqAddr0,
    input  logic [63:0] ReqAddr1,
    input  logic [63:0] ReqWData0,
    input  logic [63:0] ReqWData1,
    output logic        RspValid0,
    output logic        RspValid1,
    input  logic        RspReady0,
    input  logic        RspReady1,
    output logic [63:0] RspRData,
    output logic        RspErr,
    output logic [63:0] MemAddress,
    output logic [63:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] MemReadData
);

    state_t      state_q, state_d;
    logic        port_q, port_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        rsp_valid0_q, rsp_valid0_d;
    logic        rsp_valid1_q, rsp_valid1_d;
    logic        rsp_err_q, rsp_err_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  grant;
    logic        accept;
    logic        acc_port;
    logic        sel_write;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_err;

    rr_arbiter2 u_arb (
        .Clock  (Clock),
        .ResetL (ResetL),
        .req    ({ReqValid1, ReqValid0}),
        .update (accept),
        .last   (acc_port),
        .grant  (grant)
    );

    // Ready depends only on state and the request valids, never on RspReady.
    assign ReqReady0 = (state_q == IDLE) && ReqValid0 && grant[0];
    assign ReqReady1 = (state_q == IDLE) && ReqValid1 && grant[1];
    assign accept    = ReqReady0 || ReqReady1;
    assign acc_port  = ReqReady1;

    assign sel_write = acc_port ? ReqWrite1 : ReqWrite0;
    assign sel_addr  = acc_port ? ReqAddr1  : ReqAddr0;
    assign sel_wdata = acc_port ? ReqWData1 : ReqWData0;
    assign sel_err   = req_error(sel_addr, MEM_SIZE, CHECK_ALIGN != 0);

    // Transaction sequencer. The strobe is registered at accept so it is high
    // for exactly the CMD cycle; rejected requests take the same path but
    // never strobe the memory. Latched address/data read as zero in IDLE.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        rsp_valid0_d = rsp_valid0_q;
        rsp_valid1_d = rsp_valid1_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = CMD;
                    port_d      = acc_port;
                    write_d     = sel_write;
                    err_d       = sel_err;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    mem_read_d  = !sel_write && !sel_err;
                    mem_write_d = sel_write && !sel_err;
                end
            end
            CMD: begin
                state_d = CAPT;
            end
            CAPT: begin
                state_d      = RESP;
                rsp_rdata_d  = (write_q || err_q) ? 64'd0 : MemReadData;
                rsp_err_d    = err_q;
                rsp_valid0_d = (port_q == PORT_CPU);
                rsp_valid1_d = (port_q == PORT_DBG);
            end
            RESP: begin
                if ((rsp_valid0_q && RspReady0) || (rsp_valid1_q && RspReady1)) begin
                    state_d      = IDLE;
                    port_d       = 1'b0;
                    write_d      = 1'b0;
                    err_d        = 1'b0;
                    addr_d       = 64'd0;
                    wdata_d      = 64'd0;
                    rsp_valid0_d = 1'b0;
                    rsp_valid1_d = 1'b0;
                    rsp_err_d    = 1'b0;
                    rsp_rdata_d  = 64'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops any pending response and clears every output.
    always_ff @(posedge Clock) begin
        if (!ResetL) begin
            state_q      <= IDLE;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= 64'd0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign MemRead      = mem_read_q;
    assign MemWrite     = mem_write_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;
    assign RspValid0    = rsp_valid0_q;
    assign RspValid1    = rsp_valid1_q;
    assign RspErr       = rsp_err_q;
    assign RspRData     = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
// Self-checking bench for data_mem_arbiter with a behavioural memory behind
// it and a scoreboard fed from accepted requests.
module tb_data_mem_arbiter;

    localparam int MEM_BYTES = 1024;
    localparam int MEM_WORDS = MEM_BYTES / 8;

    logic        Clock;
    logic        ResetL;
    logic        ReqValid0, ReqValid1;
    logic        ReqReady0, ReqReady1;
    logic        ReqWrite0, ReqWrite1;
    logic [63:0] ReqAddr0, ReqAddr1;
    logic [63:0] ReqWData0, ReqWData1;
    logic        RspValid0, RspValid1;
    logic        RspReady0, RspReady1;
    logic [63:0] RspRData;
    logic        RspErr;
    logic [63:0] MemAddress;
    logic [63:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] MemReadData;

    typedef struct {
        logic        port;
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        err;
        logic [63:0] rdata;
    } expT;

    expT         sbq[$];
    logic        grantLog[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acceptCyc = 0;
    logic        busy = 1'b0;
    logic        lastGrant = 1'b1;
    int          rspMode0 = 0;
    int          rspMode1 = 0;

    logic [63:0] memData [MEM_WORDS];
    bit          memWritten [MEM_WORDS];
    logic [63:0] refMem [MEM_WORDS];
    bit          refWritten [MEM_WORDS];

    data_mem_arbiter dut (
        .Clock        (Clock),
        .ResetL       (ResetL),
        .ReqValid0    (ReqValid0),
        .ReqValid1    (ReqValid1),
        .ReqReady0    (ReqReady0),
        .ReqReady1    (ReqReady1),
        .ReqWrite0    (ReqWrite0),
        .ReqWrite1    (ReqWrite1),
        .ReqAddr0     (ReqAddr0),
        .ReqAddr1     (ReqAddr1),
        .ReqWData0    (ReqWData0),
        .ReqWData1    (ReqWData1),
        .RspValid0    (RspValid0),
        .RspValid1    (RspValid1),
        .RspReady0    (RspReady0),
        .RspReady1    (RspReady1),
        .RspRData     (RspRData),
        .RspErr       (RspErr),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemReadData  (MemReadData)
    );

    // Power-on contents of doubleword i; word 1 (address 0x8) holds 0xa.
    function automatic logic [63:0] initVal(input int i);
        return {32'(i * (i - 1) * 977), 32'(i * 10)};
    endfunction

    function automatic logic [63:0] peekMem(input int i);
        return memWritten[i] ? memData[i] : initVal(i);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // Memory with a registered read port; reset does not touch it.
    always @(posedge Clock) begin
        if (MemWrite) begin
            memData[MemAddress[9:3]]    <= MemWriteData;
            memWritten[MemAddress[9:3]] <= 1'b1;
        end
        if (MemRead) begin
            MemReadData <= memWritten[MemAddress[9:3]] ? memData[MemAddress[9:3]]
                                                       : initVal(int'(MemAddress[9:3]));
        end
    end

    // Response-ready driver: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        RspReady0 = 1'b1;
        RspReady1 = 1'b1;
        forever begin
            @(posedge Clock);
            #2;
            RspReady0 = (rspMode0 == 0) ? 1'b1 : (rspMode0 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            RspReady1 = (rspMode1 == 0) ? 1'b1 : (rspMode1 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor and reference model. Sampling at the falling edge predicts what
    // the next rising edge does: accepts push an expected response, the
    // owning port's handshake pops it. Phase counts cycles since accept.
    initial begin : monitor
        expT  cur;
        expT  nxt;
        logic exp0, exp1, goodLoad, goodStore;
        int   phase, idx;
        forever begin
            @(negedge Clock);
            if (!ResetL) begin
                busy      = 1'b0;
                lastGrant = 1'b1;
                sbq.delete();
            end else if (!busy) begin
                exp0 = ReqValid0 && (!ReqValid1 || lastGrant);
                exp1 = ReqValid1 && (!ReqValid0 || !lastGrant);
                checkOutput("idleCtl",
                    64'({MemRead, MemWrite, RspValid1, RspValid0, ReqReady1, ReqReady0}),
                    64'({4'b0000, exp1, exp0}));
                checkOutput("idleMemAddr", MemAddress, 64'd0);
                checkOutput("idleMemWData", MemWriteData, 64'd0);
                if ((ReqValid0 && ReqReady0) || (ReqValid1 && ReqReady1)) begin
                    nxt.port  = !(ReqValid0 && ReqReady0);
                    nxt.write = nxt.port ? ReqWrite1 : ReqWrite0;
                    nxt.addr  = nxt.port ? ReqAddr1 : ReqAddr0;
                    nxt.wdata = nxt.port ? ReqWData1 : ReqWData0;
                    nxt.err   = (nxt.addr % 64'd8 != 64'd0) || (nxt.addr > 64'(MEM_BYTES - 8));
                    nxt.rdata = 64'd0;
                    if (!nxt.err) begin
                        idx = int'(nxt.addr / 64'd8);
                        if (nxt.write) begin
                            refMem[idx]     = nxt.wdata;
                            refWritten[idx] = 1'b1;
                        end else begin
                            nxt.rdata = refWritten[idx] ? refMem[idx] : initVal(idx);
                        end
                    end
                    sbq.push_back(nxt);
                    grantLog.push_back(nxt.port);
                    lastGrant = nxt.port;
                    busy      = 1'b1;
                    acceptCyc = cyc + 1;
                end
            end else if (sbq.size() == 0) begin
                checkOutput("scoreboardEmpty", 64'(sbq.size()), 64'd1);
                busy = 1'b0;
            end else begin
                cur       = sbq[0];
                phase     = cyc - acceptCyc;
                goodLoad  = !cur.write && !cur.err;
                goodStore = cur.write && !cur.err;
                checkOutput("busyCtl",
                    64'({MemRead, MemWrite, RspValid1, RspValid0, ReqReady1, ReqReady0}),
                    64'({(phase == 0) && goodLoad, (phase == 0) && goodStore,
                         (phase >= 2) && cur.port, (phase >= 2) && !cur.port, 2'b00}));
                checkOutput("busyMemAddr", MemAddress, cur.addr);
                checkOutput("busyMemWData", MemWriteData, cur.wdata);
                if (phase >= 2) begin
                    checkOutput("rspRData", RspRData, cur.rdata);
                    checkOutput("rspErr", 64'(RspErr), 64'(cur.err));
                    if (cur.port ? RspReady1 : RspReady0) begin
                        void'(sbq.pop_front());
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // Drive one request on a port and hold it until accepted (bounded).
    task automatic applyStimulus(input logic port, input logic write,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        bit accepted = 0;
        @(posedge Clock);
        #1;
        if (port) begin
            ReqWrite1 = write; ReqAddr1 = addr; ReqWData1 = wdata; ReqValid1 = 1'b1;
        end else begin
            ReqWrite0 = write; ReqAddr0 = addr; ReqWData0 = wdata; ReqValid0 = 1'b1;
        end
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge Clock);
            if (port ? ReqReady1 : ReqReady0) accepted = 1;
        end
        @(posedge Clock);
        #1;
        ReqValid0 = 1'b0;
        ReqValid1 = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout port%0d actual=0 required=1", port);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL idleTimeout actual=1 required=0");
        end
    endtask

    initial begin : mainSeq
        int          n, cat;
        bit          rd0, rd1, got;
        logic [63:0] addr;
        ResetL = 1'b0;
        ReqValid0 = 0; ReqValid1 = 0; ReqWrite0 = 0; ReqWrite1 = 0;
        ReqAddr0 = 0; ReqAddr1 = 0; ReqWData0 = 0; ReqWData1 = 0;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkOutput("rstCtl", 64'({RspValid0, RspValid1, RspErr, ReqReady0, ReqReady1, MemRead, MemWrite}), 64'd0);
        checkOutput("rstRData", RspRData, 64'd0);
        checkOutput("rstMemAddr", MemAddress, 64'd0);
        checkOutput("rstMemWData", MemWriteData, 64'd0);
        @(posedge Clock);
        #1 ResetL = 1'b1;

        $display("[TB] port 0 load, port 1 store/load");
        applyStimulus(1'b0, 1'b0, 64'h8, 64'd0);
        waitIdle();
        applyStimulus(1'b1, 1'b1, 64'h18, 64'h0ffbea7deadbeeff);
        waitIdle();
        applyStimulus(1'b1, 1'b0, 64'h18, 64'd0);
        waitIdle();

        $display("[TB] both ports requesting continuously");
        grantLog.delete();
        @(posedge Clock);
        #1;
        ReqWrite0 = 0; ReqWrite1 = 0;
        ReqAddr0 = 64'($urandom_range(0, 127)) * 8;
        ReqAddr1 = 64'($urandom_range(0, 127)) * 8;
        ReqValid0 = 1; ReqValid1 = 1;
        n = 0;
        for (int c = 0; c < 100 && n < 4; c++) begin
            @(negedge Clock);
            rd0 = ReqReady0;
            rd1 = ReqReady1;
            @(posedge Clock);
            #1;
            if (rd0 || rd1) n++;
            if (rd0) ReqAddr0 = 64'($urandom_range(0, 127)) * 8;
            if (rd1) ReqAddr1 = 64'($urandom_range(0, 127)) * 8;
        end
        ReqValid0 = 0; ReqValid1 = 0;
        checkOutput("tieCount", 64'(grantLog.size()), 64'd4);
        for (int i = 0; i < grantLog.size() && i < 4; i++)
            checkOutput("tieOrder", 64'(grantLog[i]), 64'(i % 2));
        waitIdle();

        $display("[TB] rejected requests");
        applyStimulus(1'b0, 1'b0, 64'h4, 64'd0);
        waitIdle();
        applyStimulus(1'b0, 1'b1, 64'h3F9, 64'hdead_0000_beef_1111);
        waitIdle();

        $display("[TB] response stall on port 0");
        rspMode0 = 2;
        applyStimulus(1'b0, 1'b0, 64'h20, 64'd0);
        ReqWrite1 = 0; ReqAddr1 = 64'h28; ReqValid1 = 1;
        repeat (7) @(posedge Clock);
        #1 rspMode0 = 0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge Clock);
            if (ReqReady1) got = 1;
        end
        @(posedge Clock);
        #1 ReqValid1 = 0;
        checkOutput("stallDrainAccept", 64'(got), 64'd1);
        waitIdle();

        $display("[TB] reset during capture");
        applyStimulus(1'b0, 1'b0, 64'h30, 64'd0);
        @(posedge Clock);
        #1 ResetL = 1'b0;
        @(posedge Clock);
        #1 ResetL = 1'b1;
        @(negedge Clock);
        checkOutput("midRstCtl", 64'({RspValid0, RspValid1, RspErr, MemRead, MemWrite}), 64'd0);
        checkOutput("midRstRData", RspRData, 64'd0);
        checkOutput("midRstMemAddr", MemAddress, 64'd0);
        @(posedge Clock);
        #1;
        ReqWrite0 = 0; ReqWrite1 = 0; ReqAddr0 = 64'h40; ReqAddr1 = 64'h48;
        ReqValid0 = 1; ReqValid1 = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clock);
            if (ReqReady0 || ReqReady1) begin
                got = 1;
                checkOutput("tieAfterReset", 64'({ReqReady1, ReqReady0}), 64'd1);
            end
        end
        checkOutput("tieAfterResetSeen", 64'(got), 64'd1);
        @(posedge Clock);
        #1 ReqValid0 = 0; ReqValid1 = 0;
        waitIdle();

        $display("[TB] random traffic");
        rspMode0 = 1;
        rspMode1 = 1;
        for (int t = 0; t < 40; t++) begin
            cat = $urandom_range(0, 9);
            if (cat < 7)      addr = 64'($urandom_range(0, 127)) * 8;
            else if (cat < 8) addr = 64'($urandom_range(0, 127)) * 8 + 64'($urandom_range(1, 7));
            else              addr = 64'($urandom_range(1017, 2047));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, {$urandom, $urandom});
        end
        rspMode0 = 0;
        rspMode1 = 0;
        waitIdle();
        repeat (2) @(posedge Clock);

        for (int i = 0; i < MEM_WORDS; i++)
            checkOutput("memContents", peekMem(i), refWritten[i] ? refMem[i] : initVal(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
